// File: rtl/gol_video_row_streamer.sv
// Reads one Game-of-Life row per line from the ping-pong BRAM selector and
// serialises it as a valid/ready RGB pixel stream with SOF (tuser) and EOL (tlast).
module gol_video_row_streamer #(
    parameter int          X_SIZE       = 1280,
    parameter int          Y_SIZE       = 720,
    parameter int          X_WIDTH      = 11,
    parameter int          Y_WIDTH      = 10,
    parameter int          RD_LATENCY   = 1,
    parameter logic [23:0] COLOUR_ALIVE = 24'hFFFFFF,
    parameter logic [23:0] COLOUR_DEAD  = 24'h000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    output logic [Y_WIDTH-1:0] video_out_row_addr,
    input  logic [X_SIZE-1:0]  video_out_row_data,
    output logic [23:0]        m_axis_tdata,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic               m_axis_tuser,
    output logic               m_axis_tlast,
    output logic               frame_done,
    output logic               busy
);

    localparam int LAT_W = 2;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        LOAD,
        STREAM
    } state_t;

    state_t             state_q, state_d;
    logic [X_WIDTH-1:0] x_q, x_d;
    logic [Y_WIDTH-1:0] y_q, y_d;
    logic [Y_WIDTH-1:0] addr_q, addr_d;
    logic [X_SIZE-1:0]  line_q, line_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic               frame_done_q, frame_done_d;

    logic xfer;
    logic last_x;
    logic last_y;

    assign xfer   = (state_q == STREAM) && m_axis_tready;
    assign last_x = (x_q == X_WIDTH'(X_SIZE - 1));
    assign last_y = (y_q == Y_WIDTH'(Y_SIZE - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable) state_d = FETCH;
            FETCH:   if (lat_q == '0) state_d = LOAD;
            LOAD:    state_d = STREAM;
            STREAM: begin
                if (xfer && last_x) begin
                    state_d = (last_y && !enable) ? IDLE : FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Leaving IDLE waits one extra cycle so the selector's address/mode has settled
    // before the counted read latency begins; line-to-line refetches skip it.
    always_comb begin
        x_d          = x_q;
        y_d          = y_q;
        addr_d       = addr_q;
        line_d       = line_q;
        lat_d        = lat_q;
        frame_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    x_d    = '0;
                    y_d    = '0;
                    addr_d = '0;
                    lat_d  = LAT_W'(RD_LATENCY);
                end
            end
            FETCH: begin
                if (lat_q != '0) lat_d = lat_q - LAT_W'(1);
            end
            LOAD: begin
                line_d = video_out_row_data;
                x_d    = '0;
            end
            STREAM: begin
                if (xfer) begin
                    if (!last_x) begin
                        x_d = x_q + X_WIDTH'(1);
                    end else begin
                        lat_d = LAT_W'(RD_LATENCY - 1);
                        if (last_y) begin
                            y_d          = '0;
                            addr_d       = '0;
                            frame_done_d = 1'b1;
                        end else begin
                            y_d    = y_q + Y_WIDTH'(1);
                            addr_d = y_q + Y_WIDTH'(1);
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q          <= '0;
            y_q          <= '0;
            addr_q       <= '0;
            line_q       <= '0;
            lat_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            addr_q       <= addr_d;
            line_q       <= line_d;
            lat_q        <= lat_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Pixel outputs are pure functions of registered state, so they hold
    // naturally while the sink stalls and never depend on tready.
    always_comb begin
        m_axis_tvalid = (state_q == STREAM);
        m_axis_tdata  = '0;
        m_axis_tuser  = 1'b0;
        m_axis_tlast  = 1'b0;
        if (state_q == STREAM) begin
            m_axis_tdata = line_q[x_q] ? COLOUR_ALIVE : COLOUR_DEAD;
            m_axis_tuser = (x_q == '0) && (y_q == '0);
            m_axis_tlast = last_x;
        end
        busy               = (state_q != IDLE);
        frame_done         = frame_done_q;
        video_out_row_addr = addr_q;
    end

endmodule
